// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
// Op codes, ALU control words and FSM states.
package shift_seq_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   function automatic logic [3:0] alu_ctl(input logic [1:0] op);
      logic [3:0] ctl;
      case (op)
         OP_SLL:  ctl = ALU_SLL;
         OP_SRL:  ctl = ALU_SRL;
         OP_SRA:  ctl = ALU_SRA;
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Variable-distance SLL/SRL/SRA built from the ALU's shift-by-1 ops.
// Define SHIFT_SEQ_BACK2BACK_EN to accept a new request in the DONE cycle.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [WIDTH-1:0]   req_data,
   input  logic [SHAMT_W-1:0] req_shamt,
   input  logic               flush,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_err,
   output logic [WIDTH-1:0]   alu_operand_a,
   output logic [WIDTH-1:0]   alu_operand_b,
   output logic [3:0]         alu_control,
   input  logic [WIDTH-1:0]   alu_result,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [1:0]         op_q, op_d;
   logic               err_q, err_d;
   logic               accept;

   assign busy          = (state_q != IDLE);
   assign alu_operand_b = '0;
   assign accept        = req_valid && req_ready;

   always_comb begin
      req_ready = 1'b0;
      unique case (state_q)
         IDLE:    req_ready = !flush;
`ifdef SHIFT_SEQ_BACK2BACK_EN
         DONE:    req_ready = rsp_ready && !flush;
`endif
         default: req_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      count_d       = count_q;
      op_d          = op_q;
      err_d         = err_q;
      alu_operand_a = '0;
      alu_control   = ALU_ADD;
      rsp_valid     = 1'b0;
      rsp_data      = '0;
      rsp_err       = 1'b0;

      unique case (state_q)
         IDLE: ;
         SHIFT: begin
            alu_operand_a = acc_q;
            alu_control   = alu_ctl(op_q);
            acc_d         = alu_result;
            if (count_q != '0)
               count_d = count_q - 1'b1;
            if (count_q <= SHAMT_W'(1))
               state_d = DONE;
            if (flush) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_data  = acc_q;
            rsp_err   = err_q;
            if (flush || rsp_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new request overrides whatever the current state decided.
      if (accept) begin
         acc_d   = req_data;
         op_d    = req_op;
         count_d = req_shamt;
         err_d   = (req_op == OP_ILL);
         if (req_op == OP_ILL || req_shamt == '0)
            state_d = DONE;
         else
            state_d = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         op_q    <= OP_SLL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift-by-1 ALU.
// Expected values are hand-computed per scenario.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_data = '0;
   logic [4:0]  req_shamt = '0;
   logic        flush = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] alu_operand_a;
   logic [31:0] alu_operand_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      case (alu_control)
         4'b0101: alu_result = alu_operand_a << 1;
         4'b0110: alu_result = alu_operand_a >> 1;
         4'b0111: alu_result = $unsigned($signed(alu_operand_a) >>> 1);
         default: alu_result = alu_operand_a + alu_operand_b;
      endcase
   end

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_data(req_data), .req_shamt(req_shamt),
      .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_control(alu_control), .alu_result(alu_result),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request from IDLE; returns one step after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      req_shamt = sh;
      tick();
      req_valid = 1'b0;
   endtask

   // Issue, then wait (bounded) for the response; rsp_ready assumed 1.
   task automatic run_op(input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, output int lat,
                         output logic [31:0] data, output logic err,
                         output int ctl_cyc);
      int n;
      issue(op, d, sh);
      n = 1;
      ctl_cyc = 0;
      while (!rsp_valid && n < 40) begin
         if (alu_control != 4'b0000) ctl_cyc++;
         tick();
         n++;
      end
      lat  = n;
      data = rsp_data;
      err  = rsp_err;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_err, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags got=%b want=000", {rsp_valid, rsp_err, busy});
      end
      n_cmp++;
      if (rsp_data !== 32'h0 || alu_operand_a !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_data got=%h/%h want=0/0", rsp_data, alu_operand_a);
      end
      n_cmp++;
      if (alu_control !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctl got=%b want=0000", alu_control);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      tick();
   endtask

   task automatic test_sra();
      int lat, cc;
      logic [31:0] d;
      logic e;
      run_op(2'b10, 32'h8000_0000, 5'd4, lat, d, e, cc);
      n_cmp++;
      if (lat !== 5) begin
         n_bad++;
         $display("FAIL sra_latency got=%0d want=5", lat);
      end
      n_cmp++;
      if (d !== 32'hF800_0000) begin
         n_bad++;
         $display("FAIL sra_data got=%h want=f8000000", d);
      end
      n_cmp++;
      if (e !== 1'b0) begin
         n_bad++;
         $display("FAIL sra_err got=%b want=0", e);
      end
      n_cmp++;
      if (cc !== 4) begin
         n_bad++;
         $display("FAIL sra_ctl_cycles got=%0d want=4", cc);
      end
   endtask

   task automatic test_long();
      int lat, cc;
      logic [31:0] d;
      logic e;
      run_op(2'b00, 32'h0000_0001, 5'd31, lat, d, e, cc);
      n_cmp++;
      if (lat !== 32) begin
         n_bad++;
         $display("FAIL sll31_latency got=%0d want=32", lat);
      end
      n_cmp++;
      if (d !== 32'h8000_0000) begin
         n_bad++;
         $display("FAIL sll31_data got=%h want=80000000", d);
      end
      run_op(2'b01, 32'h8000_0000, 5'd31, lat, d, e, cc);
      n_cmp++;
      if (d !== 32'h0000_0001) begin
         n_bad++;
         $display("FAIL srl31_data got=%h want=00000001", d);
      end
   endtask

   task automatic test_zero_and_illegal();
      int lat, cc;
      logic [31:0] d;
      logic e;
      run_op(2'b00, 32'h1234_5678, 5'd0, lat, d, e, cc);
      n_cmp++;
      if (lat !== 1 || d !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL shamt0 got=%0d/%h want=1/12345678", lat, d);
      end
      n_cmp++;
      if (cc !== 0) begin
         n_bad++;
         $display("FAIL shamt0_ctl got=%0d want=0", cc);
      end
      run_op(2'b11, 32'hDEAD_BEEF, 5'd7, lat, d, e, cc);
      n_cmp++;
      if (lat !== 1 || e !== 1'b1 || d !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL illegal got=%0d/%b/%h want=1/1/deadbeef", lat, e, d);
      end
   endtask

   task automatic test_backpressure();
      int n;
      rsp_ready = 1'b0;
      issue(2'b01, 32'h0000_00F0, 5'd4);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/0000000f/0",
                     i, rsp_valid, rsp_data, req_ready);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_release got=%b/%b want=0/0", busy, rsp_valid);
      end
   endtask

   task automatic test_flush();
      int seen, lat, cc;
      logic [31:0] d;
      logic e;
      issue(2'b00, 32'h0000_0003, 5'd10);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_idle got=%b/%b want=0/0", busy, rsp_valid);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) seen++;
         tick();
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL flush_no_rsp got=%0d want=0", seen);
      end
      issue(2'b00, 32'h0000_0003, 5'd10);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({busy, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'h0 ||
          alu_control !== 4'b0000 || alu_operand_a !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_shift got=%b%b%b/%h/%b/%h want=000/0/0000/0",
                  busy, rsp_valid, rsp_err, rsp_data, alu_control, alu_operand_a);
      end
      flush = 1'b1;
      req_valid = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_idle_ready got=%b want=0", req_ready);
      end
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_idle_accept got=%b want=0", busy);
      end
      run_op(2'b00, 32'h0000_0003, 5'd10, lat, d, e, cc);
      n_cmp++;
      if (d !== 32'h0000_0C00 || lat !== 11) begin
         n_bad++;
         $display("FAIL after_flush got=%h/%0d want=00000c00/11", d, lat);
      end
   endtask

   task automatic test_back_to_back();
      int acc_c[2];
      int na, n, gap, want;
      na = 0;
      acc_c[0] = 0;
      acc_c[1] = 0;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_data  = 32'h0000_0001;
      req_shamt = 5'd2;
      for (int c = 0; c < 20 && na < 2; c++) begin
         #1;
         if (req_ready) begin
            acc_c[na] = c;
            na++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      gap = acc_c[1] - acc_c[0];
`ifdef SHIFT_SEQ_BACK2BACK_EN
      want = 3;
`else
      want = 4;
`endif
      n_cmp++;
      if (na !== 2 || gap !== want) begin
         n_bad++;
         $display("FAIL b2b_gap got=%0d/%0d want=2/%0d", na, gap, want);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h4) begin
         n_bad++;
         $display("FAIL b2b_data got=%b/%h want=1/00000004", rsp_valid, rsp_data);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_sra();
      test_long();
      test_zero_and_illegal();
      test_backpressure();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
